// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between N_REQ requesters.
// Latency: grant edge to rsp_valid_o is (cycles until mul_done_i) + 1; one job in flight at a time.
// Backpressure: requests are sampled only in IDLE; requesters hold req_i until their gnt_o pulse.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [2*WIDTH-1:0]     rsp_ab_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       mul_a_o,
  output logic [WIDTH-1:0]       mul_b_o,
  output logic                   mul_enable_o,
  input  logic [2*WIDTH-1:0]     mul_ab_i,
  input  logic                   mul_done_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = IW + 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  // TIMEOUT==0 disables the watchdog; TO_LAST is then never consulted.
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_q, last_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_ab_q, rsp_ab_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 en_q, en_d;

  logic [IW-1:0]        win;
  logic                 win_vld;
  logic [SW-1:0]        sum;
  logic [IW-1:0]        idx;
  logic                 done_hit;
  logic                 to_hit;

  // Completion: a real mul_done always beats a watchdog expiry in the same cycle.
  assign done_hit = (state_q == S_BUSY) && mul_done_i;
  assign to_hit   = (state_q == S_BUSY) && !mul_done_i && TO_EN && (cnt_q == TO_LAST);

  // Round-robin winner: first requester set, scanning upward from last_q+1 with wrap.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_q} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      idx = sum[IW-1:0];
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state: leave IDLE on any request, leave BUSY on done or watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_vld) state_d = S_BUSY;
      S_BUSY:  if (done_hit || to_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values; every output is registered.
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_ab_d    = rsp_ab_q;
    rsp_err_d   = 1'b0;
    busy_d      = busy_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    en_d        = en_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          owner_d = win;
          mul_a_d = req_a_i[int'(win)*WIDTH +: WIDTH];
          mul_b_d = req_b_i[int'(win)*WIDTH +: WIDTH];
          gnt_d   = ONE_HOT0 << win;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (done_hit || to_hit) begin
          rsp_valid_d = ONE_HOT0 << owner_q;
          rsp_ab_d    = done_hit ? mul_ab_i : '0;
          rsp_err_d   = !done_hit;
          en_d        = 1'b0;
          busy_d      = 1'b0;
          last_d      = owner_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; last_q resets to N_REQ-1 so requester 0 is first in line.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      owner_q     <= '0;
      last_q      <= IW'(N_REQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_ab_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      en_q        <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ab_q    <= rsp_ab_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      en_q        <= en_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_ab_o     = rsp_ab_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign mul_enable_o = en_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: scenario tasks against a transaction-level round-robin model.
// A multiplier stub answers after a programmable number of BUSY cycles (or never).
// Requesters drop their bit on gnt and optionally re-raise it on their response.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     gnt, rsp_valid;
  logic [2*W-1:0]   rsp_ab;
  logic             rsp_err, busy, mul_enable, mul_done;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_ab;

  logic signed [W-1:0] opa [N];
  logic signed [W-1:0] opb [N];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_own;

  int stub_lat   = 1;
  bit stub_never = 1'b0;
  bit force_idle_done = 1'b0;
  int bc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  end

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req), .req_a_i(req_a), .req_b_i(req_b),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_ab_o(rsp_ab), .rsp_err_o(rsp_err),
    .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_enable_o(mul_enable),
    .mul_ab_i(mul_ab), .mul_done_i(mul_done)
  );

  // Multiplier stub: done on the stub_lat-th BUSY cycle; random noise while idle.
  always @(negedge clk) begin
    if (busy) begin
      bc++;
      mul_done = !stub_never && (bc == stub_lat);
      mul_ab   = $signed(mul_a) * $signed(mul_b);
    end else begin
      bc       = 0;
      mul_done = force_idle_done | ($urandom_range(0, 1) == 1);
      mul_ab   = $urandom;
    end
  end

  // Operands must not move during a job, and enable must track busy.
  logic [W-1:0] pa, pb;
  bit pbusy = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      compared++;
      if (mul_enable !== busy) begin
        mismatched++;
        $display("FAIL enable_vs_busy: got %0b, expected %0b", mul_enable, busy);
      end
      if (busy && pbusy) begin
        compared++;
        if ({mul_a, mul_b} !== {pa, pb}) begin
          mismatched++;
          $display("FAIL operand_stable: got %0h, expected %0h", {mul_a, mul_b}, {pa, pb});
        end
      end
    end
    pa = mul_a;
    pb = mul_b;
    pbusy = busy && (rst_n === 1'b1);
  end

  // Reference round-robin choice straight from the priority rule.
  function automatic logic [N-1:0] exp_win(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [2*W-1:0] prod(input int i);
    logic signed [2*W-1:0] p;
    p = opa[i] * opb[i];
    return p;
  endfunction

  // Drives one request pattern and observes the resulting job (no checking here).
  task automatic do_job(input logic [N-1:0] reqv, input int lat, input bit never, input bit rearm,
                        output logic [N-1:0] g, output int en_cyc, output logic [N-1:0] rv,
                        output logic [2*W-1:0] ab, output logic err, output logic en_at_rsp,
                        output bit gnt_again, output int t_gnt, output int t_rsp);
    int n;
    g = '0; rv = '0; ab = '0; err = 1'b0; en_cyc = 0; en_at_rsp = 1'b1;
    gnt_again = 1'b0; t_gnt = 0; t_rsp = 0;
    stub_lat = lat; stub_never = never; req = reqv;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt === '0 && n < 50);
    if (gnt === '0) begin
      compared++; mismatched++;
      $display("FAIL grant_wait: got no grant in %0d cycles, expected a grant", n);
      req = '0;
      return;
    end
    g = gnt; t_gnt = cyc; req = req & ~gnt;
    en_cyc = mul_enable ? 1 : 0;
    n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (rsp_valid !== '0 || n >= 40) break;
      if (gnt !== '0) gnt_again = 1'b1;
      if (mul_enable) en_cyc++;
    end
    if (rsp_valid === '0) begin
      compared++; mismatched++;
      $display("FAIL rsp_wait: got no response in %0d cycles, expected one", n);
      return;
    end
    rv = rsp_valid; ab = rsp_ab; err = rsp_err; en_at_rsp = mul_enable; t_rsp = cyc;
    if (rearm) req = req | rv;
  endtask

  logic [N-1:0]   g, rv;
  logic [2*W-1:0] ab;
  logic           err, en_at_rsp;
  bit             gnt_again;
  int             en_cyc, t_gnt, t_rsp;

  task automatic test_reset();
    int n;
    rst_n = 1'b0; req = '0;
    for (int i = 0; i < N; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
    repeat (2) @(negedge clk);
    compared++;
    if ({gnt, rsp_valid, rsp_ab, rsp_err, busy, mul_a, mul_b, mul_enable} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %0h, expected 0",
               {gnt, rsp_valid, rsp_ab, rsp_err, busy, mul_a, mul_b, mul_enable});
    end
    rst_n = 1'b1;
    stub_never = 1'b1; req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt === '0 && n < 20);
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++;
      $display("FAIL reset_first_grant: got %0b, expected 0100", gnt);
    end
    req = '0;
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midjob_busy: got %0b, expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({gnt, rsp_valid, rsp_ab, rsp_err, busy, mul_a, mul_b, mul_enable} !== '0) begin
      mismatched++;
      $display("FAIL async_reset_clear: got %0h, expected 0",
               {gnt, rsp_valid, rsp_ab, rsp_err, busy, mul_a, mul_b, mul_enable});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_own = N - 1;
    do_job(4'b1111, 3, 1'b0, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
    compared++;
    if (g !== 4'b0001 || rv !== 4'b0001 || err !== 1'b0 || ab !== prod(0)) begin
      mismatched++;
      $display("FAIL post_reset_job: got g=%0b rv=%0b err=%0b ab=%0h, expected g=0001 rv=0001 err=0 ab=%0h",
               g, rv, err, ab, prod(0));
    end
    req = '0;
    last_own = 0;
  endtask

  task automatic test_single_job();
    for (int i = 0; i < N; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
    opa[2] = -16'sd3; opb[2] = 16'sd7;
    do_job(4'b0100, 5, 1'b0, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
    compared++;
    if (g !== 4'b0100 || gnt_again) begin
      mismatched++;
      $display("FAIL single_gnt: got %0b again=%0b, expected 0100 once", g, gnt_again);
    end
    compared++;
    if (en_cyc != 5 || en_at_rsp !== 1'b0) begin
      mismatched++;
      $display("FAIL single_enable: got %0d cycles (at rsp %0b), expected 5 (0)", en_cyc, en_at_rsp);
    end
    compared++;
    if (rv !== 4'b0100 || ab !== 32'hFFFF_FFEB || err !== 1'b0) begin
      mismatched++;
      $display("FAIL single_rsp: got rv=%0b ab=%0h err=%0b, expected rv=0100 ab=ffffffeb err=0", rv, ab, err);
    end
    compared++;
    if (t_rsp - t_gnt != 5) begin
      mismatched++;
      $display("FAIL single_latency: got %0d, expected 5", t_rsp - t_gnt);
    end
    @(negedge clk);
    compared++;
    if (rsp_valid !== '0 || rsp_ab !== 32'hFFFF_FFEB) begin
      mismatched++;
      $display("FAIL rsp_hold: got rv=%0b ab=%0h, expected rv=0 ab=ffffffeb", rsp_valid, rsp_ab);
    end
    last_own = 2;
  endtask

  task automatic test_idle_done();
    req = '0; force_idle_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || rsp_valid !== '0 || gnt !== '0) begin
        mismatched++;
        $display("FAIL idle_done_ignored: got busy=%0b rv=%0b gnt=%0b, expected all 0", busy, rsp_valid, gnt);
      end
    end
    force_idle_done = 1'b0;
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_g [3];
    logic [N-1:0] pats  [3];
    pats[0] = 4'b1000; pats[1] = 4'b1001; pats[2] = 4'b1001;
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b1000;
    for (int j = 0; j < 3; j++) begin
      do_job(pats[j], 2, 1'b0, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
      compared++;
      if (g !== exp_g[j] || rv !== exp_g[j]) begin
        mismatched++;
        $display("FAIL wrap_%0d: got g=%0b rv=%0b, expected %0b", j, g, rv, exp_g[j]);
      end
    end
    last_own = 3;
  endtask

  task automatic test_timeout();
    do_job(4'b0010, 1, 1'b1, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
    compared++;
    if (rv !== 4'b0010 || err !== 1'b1 || ab !== '0) begin
      mismatched++;
      $display("FAIL timeout_rsp: got rv=%0b err=%0b ab=%0h, expected rv=0010 err=1 ab=0", rv, err, ab);
    end
    compared++;
    if (en_cyc != TO || en_at_rsp !== 1'b0 || t_rsp - t_gnt != TO) begin
      mismatched++;
      $display("FAIL timeout_timing: got en=%0d lat=%0d en_at_rsp=%0b, expected %0d %0d 0",
               en_cyc, t_rsp - t_gnt, en_at_rsp, TO, TO);
    end
    @(negedge clk);
    compared++;
    if (rsp_err !== 1'b0 || rsp_valid !== '0) begin
      mismatched++;
      $display("FAIL timeout_clear: got err=%0b rv=%0b, expected 0 0", rsp_err, rsp_valid);
    end
    last_own = 1;
  endtask

  task automatic test_collision();
    opa[0] = W'($urandom); opb[0] = W'($urandom);
    do_job(4'b0001, TO, 1'b0, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
    compared++;
    if (rv !== 4'b0001 || err !== 1'b0 || ab !== prod(0) || t_rsp - t_gnt != TO) begin
      mismatched++;
      $display("FAIL collision: got rv=%0b err=%0b ab=%0h lat=%0d, expected 0001 0 %0h %0d",
               rv, err, ab, t_rsp - t_gnt, prod(0), TO);
    end
    last_own = 0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seen, eg;
    int prev_rsp, lat;
    do_job(4'b1000, 2, 1'b0, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
    last_own = 3;
    seen = '0; prev_rsp = -1;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < N; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
      lat = $urandom_range(1, 6);
      eg = exp_win(4'b1111, last_own);
      do_job(j == 0 ? 4'b1111 : req, lat, 1'b0, 1'b1, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
      compared++;
      if (g !== eg || rv !== eg || ab !== prod(idx_of(eg)) || err !== 1'b0) begin
        mismatched++;
        $display("FAIL rr_job_%0d: got g=%0b rv=%0b ab=%0h err=%0b, expected g=%0b ab=%0h err=0",
                 j, g, rv, ab, err, eg, prod(idx_of(eg)));
      end
      compared++;
      if ((seen & g) !== '0) begin
        mismatched++;
        $display("FAIL rr_fairness_%0d: got regrant %0b, expected one of %0b", j, g, ~seen);
      end
      seen = ((seen | g) == 4'b1111) ? '0 : (seen | g);
      if (prev_rsp >= 0) begin
        compared++;
        if (t_gnt - prev_rsp != 1 || t_rsp - t_gnt != lat) begin
          mismatched++;
          $display("FAIL rr_spacing_%0d: got gap=%0d lat=%0d, expected gap=1 lat=%0d",
                   j, t_gnt - prev_rsp, t_rsp - t_gnt, lat);
        end
      end
      prev_rsp = t_rsp;
      last_own = idx_of(eg);
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] r, eg;
    logic [2*W-1:0] eab;
    int lat, elat;
    bit never, eerr;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < N; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
      r     = N'($urandom_range(1, 15));
      lat   = $urandom_range(1, 10);
      never = (lat > TO);
      eg    = exp_win(r, last_own);
      eerr  = never;
      eab   = never ? '0 : prod(idx_of(eg));
      elat  = never ? TO : lat;
      do_job(r, lat, never, 1'b0, g, en_cyc, rv, ab, err, en_at_rsp, gnt_again, t_gnt, t_rsp);
      compared++;
      if (g !== eg || rv !== eg || ab !== eab || err !== eerr || t_rsp - t_gnt != elat) begin
        mismatched++;
        $display("FAIL rand_%0d: got g=%0b rv=%0b ab=%0h err=%0b lat=%0d, expected g=%0b ab=%0h err=%0b lat=%0d",
                 j, g, rv, ab, err, t_rsp - t_gnt, eg, eab, eerr, elat);
      end
      last_own = idx_of(eg);
    end
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    test_reset();
    test_single_job();
    test_idle_done();
    test_wrap();
    test_timeout();
    test_collision();
    test_round_robin();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
